prefix_adder_pipe: RTL and testbench
====================================

Name: prefix_adder_pipe

Overview:
- Elastic, pipelined parallel-prefix adder built on the prefix-tree datapath, generalised in three ways.
- Topology is selectable: Kogge-Stone, Sklansky or Brent-Kung.
- Pipeline depth is selectable by levels-per-stage.
- Operands can be split into independent SIMD lanes via a segment mask.
- Carries a valid/ready handshake with full backpressure. Intended as the carry engine feeding the final CPA of the multiplier.

Parameters:
- WIDTH, 16: operand width in bits; power of two, 4..128.
- TECHNIQUE, 0: prefix topology; 0=Kogge-Stone, 1=Sklansky, 2=Brent-Kung.
- LEVELS_PER_STAGE, 1: prefix levels between pipeline registers; 0 = fully combinational.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- cin  input  1  carry-in applied at the start of every segment.
- seg_in  input  WIDTH  bit i=1: bit i starts a new lane; bit 0 is always a lane start.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum_out  output  WIDTH  per-lane sum.
- cout_out  output  WIDTH  carry out of each bit position.

Behaviour:
- Levels and latency:
  - L = clog2(WIDTH) for TECHNIQUE 0/1; L = 2*clog2(WIDTH)-1 for TECHNIQUE 2.
  - LEVELS_PER_STAGE>0: S = ceil(L/LEVELS_PER_STAGE) register stages; latency S cycles from accepted beat to out_valid.
  - LEVELS_PER_STAGE=0: latency 0, out_valid=in_valid, in_ready=out_ready.
- Transfers: a beat is accepted when in_valid&&in_ready; a result is consumed when out_valid&&out_ready.
- Stage advance: each stage k holds valid[k]. Stage k loads when !valid[k] || advance[k+1]; the last stage advances on out_ready. in_ready = stage-0 load condition.
  - Throughput is 1 beat/cycle when unstalled.
  - Bubbles collapse; no beat is dropped or duplicated; order is preserved.
- Stalls: while out_valid&&!out_ready, sum_out and cout_out hold stable.
- Per-bit terms: g_i=a_i&b_i, p_i=a_i^b_i.
- Carries: c_in(i) = cin if bit i is a lane start, else cout(i-1). cout(i) = g_i | p_i&c_in(i). Carries never cross a lane start.
- Sum: sum_i = p_i ^ c_in(i).
- seg_in is sampled with the operands and travels with the beat.
- seg_in=0 gives a single WIDTH-bit add.
- seg_in=all-ones gives WIDTH 1-bit adds.
- Lanes of unequal width are legal.
- Reset (rst=0): all stage valids clear; out_valid=0, sum_out=0, cout_out=0; in_ready=1 immediately after release.
- Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- Simultaneous accept and consume on a full pipeline is legal and keeps occupancy constant.

Optional Feature:
- Macro PREFIX_OVF_EN.
- Defined: adds output ovf_out [WIDTH]. Bit i = c_in(i)^cout(i) when bit i is the top bit of a lane (bit WIDTH-1, or seg_in[i+1]=1); otherwise 0. It is the signed overflow per lane, registered alongside sum_out with identical latency, stall and reset (0) behaviour.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- WIDTH=16, TECHNIQUE=0, LEVELS_PER_STAGE=1, a=0xFFFF, b=0x0001, cin=0, seg=0 -> after 4 cycles sum_out=0x0000, cout_out=0xFFFF.
- seg=0x0100, a=0x80FF, b=0x8001, cin=0 -> sum_out=0x0000, cout_out=0x80FF; no carry crosses from bit 7 to bit 8.
- seg=0x1111, a=0x0000, b=0xFFFF, cin=1 -> sum_out=0x0000, cout_out=0xFFFF.
- TECHNIQUE=2, LEVELS_PER_STAGE=2:
  - 20 back-to-back random beats with out_ready low for 3 cycles mid-stream -> first out_valid 4 cycles after first accept.
  - in_ready drops once 4 beats are held.
  - All 20 results match the golden model, in order, with no loss.
- Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 immediately and stays 0 until new beats arrive; none of the old results emerge.
- PREFIX_OVF_EN defined, seg=0x0100, a=0x7F7F, b=0x0101, cin=0 -> sum_out=0x8080, ovf_out=0x8080.

Source files
------------

// File: rtl/prefix_adder_pipe.sv
// Elastic pipelined parallel-prefix adder with SIMD lane segmentation; `PREFIX_OVF_EN adds ovf_out.
// Latency ceil(L/LEVELS_PER_STAGE) cycles (0 when LEVELS_PER_STAGE=0, pure combinational).
// Backpressure: per-stage valid/ready, bubbles collapse, outputs hold while out_valid && !out_ready.
module prefix_adder_pipe #(
   parameter int WIDTH            = 16,
   parameter int TECHNIQUE        = 0,
   parameter int LEVELS_PER_STAGE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   input  logic [WIDTH-1:0] seg_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum_out,
`ifdef PREFIX_OVF_EN
   output logic [WIDTH-1:0] cout_out,
   output logic [WIDTH-1:0] ovf_out
`else
   output logic [WIDTH-1:0] cout_out
`endif
);

   localparam int LG    = $clog2(WIDTH);
   localparam int NLVL  = (TECHNIQUE == 2) ? 2*LG - 1 : LG;
   localparam int LPS_D = (LEVELS_PER_STAGE > 0) ? LEVELS_PER_STAGE : 1;
   localparam int NSTG  = (LEVELS_PER_STAGE > 0) ? (NLVL + LPS_D - 1) / LPS_D : 0;

   // g/p are the running group terms; pb keeps the raw bit propagate for the sum.
   typedef struct packed {
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] pb;
      logic [WIDTH-1:0] st;
      logic             ci;
   } stage_t;

   // One prefix level; a lane start has P=0 so no carry ever crosses it.
   function automatic stage_t f_level(input stage_t x, input int lvl);
      stage_t          y;
      int              j;
      int              d;
      logic            hit;
      logic [LG-1:0]   ii;
      logic [LG-1:0]   jj;
      y = x;
      for (int i = 0; i < WIDTH; i++) begin
         hit = 1'b0;
         j   = 0;
         d   = 1;
         if (TECHNIQUE == 0) begin
            j   = i - (1 << lvl);
            hit = (j >= 0);
         end else if (TECHNIQUE == 1) begin
            hit = ((i >> lvl) & 1) == 1;
            j   = ((i >> (lvl + 1)) << (lvl + 1)) + (1 << lvl) - 1;
         end else if (lvl < LG) begin
            hit = ((i + 1) % (2 << lvl)) == 0;
            j   = i - (1 << lvl);
         end else begin
            d   = 1 << (2*LG - 2 - lvl);
            hit = (((i + 1) % (2*d)) == d) && ((i + 1) >= 3*d);
            j   = i - d;
         end
         if (hit) begin
            ii      = LG'(i);
            jj      = LG'(j);
            y.g[ii] = x.g[ii] | (x.p[ii] & x.g[jj]);
            y.p[ii] = x.p[ii] & x.p[jj];
         end
      end
      return y;
   endfunction

   logic [WIDTH-1:0] w_st;
   stage_t           w_init;
   logic [WIDTH-1:0] w_fin_g;
   logic [WIDTH-1:0] w_fin_pb;
   logic [WIDTH-1:0] w_fin_st;
   logic             w_fin_ci;
   logic [WIDTH-1:0] w_cin_vec;

   assign w_st = seg_in | WIDTH'(1);

   // cin is folded into the generate term of every lane-start bit.
   always_comb begin
      w_init.g  = (a_in & b_in) | ((a_in ^ b_in) & w_st & {WIDTH{cin}});
      w_init.p  = (a_in ^ b_in) & ~w_st;
      w_init.pb = a_in ^ b_in;
      w_init.st = w_st;
      w_init.ci = cin;
   end

   if (LEVELS_PER_STAGE > 0) begin : g_pipe
      stage_t          w_stg_d [NSTG];
      stage_t          r_stg   [NSTG];
      logic [NSTG-1:0] r_vld;
      logic [NSTG-1:0] w_ld;

      always_comb begin
         stage_t t;
         int     lend;
         for (int s = 0; s < NSTG; s++) begin
            if (s == 0) t = w_init;
            else        t = r_stg[s-1];
            lend = ((s + 1) * LEVELS_PER_STAGE < NLVL) ? (s + 1) * LEVELS_PER_STAGE : NLVL;
            for (int l = s * LEVELS_PER_STAGE; l < lend; l++) t = f_level(t, l);
            w_stg_d[s] = t;
         end
      end

      // Stage k loads when it is empty or everything downstream of it is moving.
      always_comb begin
         logic acc;
         acc  = out_ready;
         w_ld = '0;
         for (int s = NSTG - 1; s >= 0; s--) begin
            acc     = acc | ~r_vld[s];
            w_ld[s] = acc;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_vld <= '0;
            for (int s = 0; s < NSTG; s++) r_stg[s] <= '0;
         end else begin
            if (w_ld[0]) begin
               r_vld[0] <= in_valid;
               r_stg[0] <= w_stg_d[0];
            end
            for (int s = 1; s < NSTG; s++) begin
               if (w_ld[s]) begin
                  r_vld[s] <= r_vld[s-1];
                  r_stg[s] <= w_stg_d[s];
               end
            end
         end
      end

      assign in_ready  = w_ld[0];
      assign out_valid = r_vld[NSTG-1];
      assign w_fin_g   = r_stg[NSTG-1].g;
      assign w_fin_pb  = r_stg[NSTG-1].pb;
      assign w_fin_st  = r_stg[NSTG-1].st;
      assign w_fin_ci  = r_stg[NSTG-1].ci;
   end else begin : g_comb
      always_comb begin
         stage_t t;
         t = w_init;
         for (int l = 0; l < NLVL; l++) t = f_level(t, l);
         w_fin_g  = t.g;
         w_fin_pb = t.pb;
         w_fin_st = t.st;
         w_fin_ci = t.ci;
      end

      assign in_ready  = out_ready;
      assign out_valid = in_valid;
   end

   assign w_cin_vec = (w_fin_st & {WIDTH{w_fin_ci}}) | (~w_fin_st & {w_fin_g[WIDTH-2:0], 1'b0});
   assign sum_out   = w_fin_pb ^ w_cin_vec;
   assign cout_out  = w_fin_g;

`ifdef PREFIX_OVF_EN
   // A bit is a lane top when the next bit starts a lane or it is the MSB.
   assign ovf_out = {1'b1, w_fin_st[WIDTH-1:1]} & (w_cin_vec ^ w_fin_g);
`endif

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed bench for prefix_adder_pipe: vector table across four configurations, stall stream, mid-flight reset.
module tb_prefix_adder_pipe;
   localparam int W = 16;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] seg;
      logic         ci;
      logic [W-1:0] es;
      logic [W-1:0] ec;
      logic [W-1:0] eo;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] a, b, seg;
   logic         ci;
   logic [3:0]   iv, ordy;
   logic         ir [4];
   logic         ov [4];
   logic [W-1:0] sm [4];
   logic [W-1:0] co [4];
`ifdef PREFIX_OVF_EN
   logic [W-1:0] of [4];
`endif
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prefix_adder_pipe #(.WIDTH(W), .TECHNIQUE(0), .LEVELS_PER_STAGE(1)) u0 (
      .clk(clk), .rst(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a_in(a), .b_in(b), .cin(ci),
      .seg_in(seg), .out_valid(ov[0]), .out_ready(ordy[0]), .sum_out(sm[0]),
`ifdef PREFIX_OVF_EN
      .ovf_out(of[0]),
`endif
      .cout_out(co[0]));

   prefix_adder_pipe #(.WIDTH(W), .TECHNIQUE(2), .LEVELS_PER_STAGE(2)) u1 (
      .clk(clk), .rst(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a_in(a), .b_in(b), .cin(ci),
      .seg_in(seg), .out_valid(ov[1]), .out_ready(ordy[1]), .sum_out(sm[1]),
`ifdef PREFIX_OVF_EN
      .ovf_out(of[1]),
`endif
      .cout_out(co[1]));

   prefix_adder_pipe #(.WIDTH(W), .TECHNIQUE(0), .LEVELS_PER_STAGE(3)) u2 (
      .clk(clk), .rst(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a_in(a), .b_in(b), .cin(ci),
      .seg_in(seg), .out_valid(ov[2]), .out_ready(ordy[2]), .sum_out(sm[2]),
`ifdef PREFIX_OVF_EN
      .ovf_out(of[2]),
`endif
      .cout_out(co[2]));

   prefix_adder_pipe #(.WIDTH(W), .TECHNIQUE(1), .LEVELS_PER_STAGE(0)) u3 (
      .clk(clk), .rst(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .a_in(a), .b_in(b), .cin(ci),
      .seg_in(seg), .out_valid(ov[3]), .out_ready(ordy[3]), .sum_out(sm[3]),
`ifdef PREFIX_OVF_EN
      .ovf_out(of[3]),
`endif
      .cout_out(co[3]));

   // Bit-serial ripple reference: {sum, cout, ovf}.
   function automatic logic [3*W-1:0] model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                            input logic [W-1:0] fs, input logic fc);
      logic [W:0]   top;
      logic         c;
      logic [W-1:0] s, o, v;
      top = {1'b1, fs};
      c = fc; s = '0; o = '0; v = '0;
      for (int i = 0; i < W; i++) begin
         if (i == 0 || fs[i]) c = fc;
         s[i] = fa[i] ^ fb[i] ^ c;
         o[i] = (fa[i] & fb[i]) | ((fa[i] ^ fb[i]) & c);
         v[i] = top[i+1] & (c ^ o[i]);
         c = o[i];
      end
      return {s, o, v};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t         vt [11];
      int           exp_lat [3];
      int           lat [3];
      logic [W-1:0] sa [20];
      logic [W-1:0] sb [20];
      logic [W-1:0] ss [20];
      logic         sc [20];
      logic [3*W-1:0] m;
      int           sent, got, cyc, first_acc, first_ov, occ, bad, l1;
      logic         saw_full, stalled;
      logic [W-1:0] held;

      vt[0]  = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0000, 16'hFFFF, 16'h0000};
      vt[1]  = '{16'h80FF, 16'h8001, 16'h0100, 1'b0, 16'h0000, 16'h80FF, 16'h8000};
      vt[2]  = '{16'h0000, 16'hFFFF, 16'h1111, 1'b1, 16'h0000, 16'hFFFF, 16'h0000};
      vt[3]  = '{16'h7F7F, 16'h0101, 16'h0100, 1'b0, 16'h8080, 16'h7F7F, 16'h8080};
      vt[4]  = '{16'h00FF, 16'h0F0F, 16'hFFFF, 1'b0, 16'h0FF0, 16'h000F, 16'h000F};
      vt[5]  = '{16'h00FF, 16'h0F0F, 16'hFFFF, 1'b1, 16'hF00F, 16'h0FFF, 16'hF000};
      vt[6]  = '{16'h0001, 16'h0000, 16'h0000, 1'b1, 16'h0002, 16'h0001, 16'h0000};
      vt[7]  = '{16'h8000, 16'h8000, 16'h0000, 1'b0, 16'h0000, 16'h8000, 16'h8000};
      vt[8]  = '{16'h000F, 16'h0001, 16'h0010, 1'b0, 16'h0000, 16'h000F, 16'h0000};
      vt[9]  = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0, 16'h0000, 16'h7FFF, 16'h0000};
      vt[10] = '{16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000};
      exp_lat = '{4, 4, 2};

      rst_n = 1'b0; iv = '0; ordy = 4'b1000; a = '0; b = '0; seg = '0; ci = 1'b0;
      tick(); tick();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset out_valid u%0d", d), 32'(ov[d]), 0);
         chk($sformatf("reset sum u%0d", d), 32'(sm[d]), 0);
         chk($sformatf("reset cout u%0d", d), 32'(co[d]), 0);
      end
      rst_n = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) chk($sformatf("post-reset in_ready u%0d", d), 32'(ir[d]), 1);
      tick();

      // Single beats through every configuration, results held until consumed.
      for (int v = 0; v < 11; v++) begin
         a = vt[v].a; b = vt[v].b; seg = vt[v].seg; ci = vt[v].ci;
         iv = 4'b1111;
         #1;
         chk($sformatf("v%0d comb valid", v), 32'(ov[3]), 1);
         chk($sformatf("v%0d comb sum", v), 32'(sm[3]), 32'(vt[v].es));
         chk($sformatf("v%0d comb cout", v), 32'(co[3]), 32'(vt[v].ec));
`ifdef PREFIX_OVF_EN
         chk($sformatf("v%0d comb ovf", v), 32'(of[3]), 32'(vt[v].eo));
`endif
         for (int d = 0; d < 3; d++) chk($sformatf("v%0d in_ready u%0d", v, d), 32'(ir[d]), 1);
         tick();
         iv = '0;
         lat = '{-1, -1, -1};
         for (int k = 1; k <= 6; k++) begin
            for (int d = 0; d < 3; d++) if (ov[d] && lat[d] < 0) lat[d] = k;
            if (k < 6) tick();
         end
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("v%0d latency u%0d", v, d), 32'(lat[d]), 32'(exp_lat[d]));
            chk($sformatf("v%0d sum u%0d", v, d), 32'(sm[d]), 32'(vt[v].es));
            chk($sformatf("v%0d cout u%0d", v, d), 32'(co[d]), 32'(vt[v].ec));
`ifdef PREFIX_OVF_EN
            chk($sformatf("v%0d ovf u%0d", v, d), 32'(of[d]), 32'(vt[v].eo));
`endif
         end
         ordy[2:0] = 3'b111;
         tick();
         ordy[2:0] = 3'b000;
         for (int d = 0; d < 3; d++) chk($sformatf("v%0d consumed u%0d", v, d), 32'(ov[d]), 0);
      end

      // Back-to-back stream into the Brent-Kung pipe with a 3-cycle output stall.
      for (int i = 0; i < 20; i++) begin
         sa[i] = W'($urandom); sb[i] = W'($urandom);
         ss[i] = W'($urandom); sc[i] = 1'($urandom);
      end
      sent = 0; got = 0; cyc = 0; first_acc = -1; first_ov = -1; occ = 0;
      saw_full = 1'b0; stalled = 1'b0; held = '0;
      while (got < 20 && cyc < 200) begin
         ordy[1] = !(cyc >= 8 && cyc < 11);
         iv[1] = (sent < 20);
         if (sent < 20) begin
            a = sa[sent]; b = sb[sent]; seg = ss[sent]; ci = sc[sent];
         end
         #1;
         if (iv[1] && ir[1] && first_acc < 0) first_acc = cyc;
         if (ov[1] && first_ov < 0) first_ov = cyc;
         if (!ir[1]) begin
            saw_full = 1'b1;
            chk($sformatf("stream occupancy at in_ready low c%0d", cyc), 32'(occ), 4);
         end
         if (ov[1] && !ordy[1]) begin
            if (stalled) chk($sformatf("stream stall hold c%0d", cyc), 32'(sm[1]), 32'(held));
            held = sm[1];
            stalled = 1'b1;
         end else begin
            stalled = 1'b0;
         end
         if (ov[1] && ordy[1]) begin
            m = model(sa[got], sb[got], ss[got], sc[got]);
            chk($sformatf("stream sum #%0d", got), 32'(sm[1]), 32'(m[3*W-1:2*W]));
            chk($sformatf("stream cout #%0d", got), 32'(co[1]), 32'(m[2*W-1:W]));
`ifdef PREFIX_OVF_EN
            chk($sformatf("stream ovf #%0d", got), 32'(of[1]), 32'(m[W-1:0]));
`endif
            got++;
            occ--;
         end
         if (iv[1] && ir[1]) begin
            sent++;
            occ++;
         end
         tick();
         cyc++;
      end
      iv[1] = 1'b0;
      chk("stream results delivered", 32'(got), 20);
      chk("stream beats accepted", 32'(sent), 20);
      chk("stream first latency", 32'(first_ov - first_acc), 4);
      chk("stream in_ready dropped", 32'(saw_full), 1);

      // Reset with three beats in flight.
      ordy[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a = sa[k]; b = sb[k]; seg = ss[k]; ci = sc[k];
         iv[1] = 1'b1;
         tick();
      end
      iv[1] = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid reset out_valid", 32'(ov[1]), 0);
      chk("mid reset sum", 32'(sm[1]), 0);
      chk("mid reset cout", 32'(co[1]), 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("after reset in_ready", 32'(ir[1]), 1);
      ordy[1] = 1'b1;
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         if (ov[1]) bad++;
         tick();
      end
      chk("after reset no stale results", 32'(bad), 0);
      a = vt[1].a; b = vt[1].b; seg = vt[1].seg; ci = vt[1].ci;
      iv[1] = 1'b1;
      tick();
      iv[1] = 1'b0;
      l1 = -1;
      for (int k = 1; k <= 10; k++) begin
         if (ov[1] && l1 < 0) begin
            l1 = k;
            chk("after reset sum", 32'(sm[1]), 32'(vt[1].es));
            chk("after reset cout", 32'(co[1]), 32'(vt[1].ec));
         end
         tick();
      end
      chk("after reset latency", 32'(l1), 4);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
